// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared vector datapath types and FP16 helpers
package vector_pkg;

  typedef logic [15:0] fp16_t;

  localparam int VSQ_LANES = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } vsqrt_seq_state_t;

  function automatic logic fp16_is_nan(input fp16_t x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/vsqrt_seq.sv
// rtl/vsqrt_seq.sv - serialises masked FP16 vector lanes through a scalar sqrt unit
module vsqrt_seq
  import vector_pkg::*;
#(
  parameter int LANES = VSQ_LANES,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*16-1:0]   in_vec,
  input  logic [LANES-1:0]      in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*16-1:0]   out_vec,
  output logic [LANES-1:0]      out_nan,
  output logic                  sq_valid_in,
  input  logic                  sq_ready,
  output logic [15:0]           sq_data_in,
  input  logic                  sq_valid_out,
  input  logic [15:0]           sq_data_out
);

  vsqrt_seq_state_t      state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LANES*16-1:0]   buf_q, buf_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [LANES-1:0]      nan_q, nan_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  fp16_t                 cur_lane;
  logic                  last_lane;
  logic                  issue_fire;

  assign cur_lane   = buf_q[16*idx_q +: 16];
  assign last_lane  = (idx_q == IDX_W'(LANES - 1));
  // Issue depends on the live sq_ready, so it cannot be a registered output.
  assign issue_fire = (state_q == ISSUE) && mask_q[idx_q] && sq_ready;

  assign sq_valid_in = issue_fire;
  assign sq_data_in  = issue_fire ? cur_lane : 16'h0000;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_vec     = buf_q;
  assign out_nan     = nan_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    mask_d      = mask_q;
    nan_d       = nan_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d      = in_vec;
          mask_d     = in_mask;
          nan_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (!mask_q[idx_q]) begin
          if (last_lane) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (sq_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (sq_valid_out) begin
          buf_d[16*idx_q +: 16] = sq_data_out;
          nan_d[idx_q]          = fp16_is_nan(sq_data_out);
          if (last_lane) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      buf_q       <= '0;
      mask_q      <= '0;
      nan_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      mask_q      <= mask_d;
      nan_q       <= nan_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_vsqrt_seq.sv
// tb/tb_vsqrt_seq.sv - randomized self-checking bench for vsqrt_seq with a scalar sqrt stub
module tb_vsqrt_seq;

  localparam int LANES = 8;

  logic                 CLK;
  logic                 RST;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*16-1:0]  in_vec;
  logic [LANES-1:0]     in_mask;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*16-1:0]  out_vec;
  logic [LANES-1:0]     out_nan;
  logic                 sq_valid_in;
  logic                 sq_ready;
  logic [15:0]          sq_data_in;
  logic                 sq_valid_out;
  logic [15:0]          sq_data_out;

  logic                 stub_vo, spur_vo;
  logic [15:0]          stub_do, spur_data, stub_held, stub_din;
  logic                 stub_busy, stub_take;
  int                   stub_lat, lat_min, lat_max;
  bit                   stall_en;
  int                   pulses, proto_err;
  int                   pass_cnt, total_cnt;

  assign sq_valid_out = stub_vo | spur_vo;
  assign sq_data_out  = spur_vo ? spur_data : stub_do;

  vsqrt_seq #(.LANES(LANES)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_nan(out_nan),
    .sq_valid_in(sq_valid_in), .sq_ready(sq_ready), .sq_data_in(sq_data_in),
    .sq_valid_out(sq_valid_out), .sq_data_out(sq_data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Abstract sqrt unit: known values map to true square roots, others to a fixed scramble.
  function automatic logic [15:0] ref_sqrt(input logic [15:0] x);
    case (x)
      16'h4400: return 16'h4000;
      16'h3C00: return 16'h3C00;
      16'hBC00: return 16'h7D00;
      default:  return {x[7:0], x[15:8]} ^ 16'h00FF;
    endcase
  endfunction

  function automatic bit is_nan16(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  task automatic model(input logic [127:0] v, input logic [7:0] m,
                       output logic [127:0] ev, output logic [7:0] en);
    logic [15:0] r;
    ev = v;
    en = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        r = ref_sqrt(v[16*i +: 16]);
        ev[16*i +: 16] = r;
        en[i] = is_nan16(r);
      end
    end
  endtask

  always @(posedge CLK) begin
    stub_take = sq_valid_in && sq_ready;
    stub_din  = sq_data_in;
    if (sq_valid_in && stub_busy) proto_err++;
    #1;
    if (RST) begin
      stub_busy = 1'b0;
      stub_vo   = 1'b0;
      sq_ready  = 1'b1;
    end else begin
      stub_vo = 1'b0;
      if (stub_take) begin
        pulses++;
        stub_busy = 1'b1;
        stub_held = ref_sqrt(stub_din);
        stub_lat  = $urandom_range(lat_max, lat_min);
        sq_ready  = 1'b0;
      end else if (stub_busy) begin
        stub_lat--;
        if (stub_lat <= 0) begin
          stub_vo   = 1'b1;
          stub_do   = stub_held;
          stub_busy = 1'b0;
        end
      end else begin
        sq_ready = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
      end
    end
  end

  task automatic run_vector(input logic [127:0] v, input logic [7:0] m,
                            output logic [127:0] gv, output logic [7:0] gn,
                            output int lat, output int np, output bit to);
    int p0, n;
    to = 0;
    n = 0;
    @(negedge CLK);
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    in_valid = 1'b1;
    in_vec   = v;
    in_mask  = m;
    p0 = pulses;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_vec   = {$urandom, $urandom, $urandom, $urandom};
    in_mask  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    to = !out_valid;
    gv = out_vec;
    gn = out_nan;
    np = pulses - p0;
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (sq_valid_in !== 1'b0 || sq_data_in !== 16'h0) $display("FAIL reset_sq got=%b/%h exp=0/0000", sq_valid_in, sq_data_in); else pass_cnt++;
    total_cnt++; if (out_vec !== '0 || out_nan !== '0) $display("FAIL reset_out got=%h/%h exp=0/0", out_vec, out_nan); else pass_cnt++;
  endtask

  task automatic test_full_mask();
    logic [127:0] v, gv, ev; logic [7:0] gn, en; int lat, np; bit to;
    lat_min = 1; lat_max = 1; stall_en = 0;
    v = {LANES{16'h4400}};
    model(v, 8'hFF, ev, en);
    run_vector(v, 8'hFF, gv, gn, lat, np, to);
    total_cnt++; if (to || gv !== ev) $display("FAIL full_vec got=%h exp=%h", gv, ev); else pass_cnt++;
    total_cnt++; if (gn !== en) $display("FAIL full_nan got=%h exp=%h", gn, en); else pass_cnt++;
    total_cnt++; if (np != 8) $display("FAIL full_pulses got=%0d exp=8", np); else pass_cnt++;
    total_cnt++; if (lat != 8 * (2 + 1)) $display("FAIL full_latency got=%0d exp=%0d", lat, 24); else pass_cnt++;
    total_cnt++; if (proto_err != 0) $display("FAIL full_inflight got=%0d exp=0", proto_err); else pass_cnt++;
  endtask

  task automatic test_half_mask();
    logic [127:0] v, gv, ev; logic [7:0] gn, en; int lat, np; bit to;
    lat_min = 1; lat_max = 1; stall_en = 0;
    v = {$urandom, $urandom, {4{16'h3C00}}};
    model(v, 8'h0F, ev, en);
    run_vector(v, 8'h0F, gv, gn, lat, np, to);
    total_cnt++; if (to || gv !== ev) $display("FAIL half_vec got=%h exp=%h", gv, ev); else pass_cnt++;
    total_cnt++; if (np != 4) $display("FAIL half_pulses got=%0d exp=4", np); else pass_cnt++;
    total_cnt++; if (lat != 4 * (2 + 1) + 4) $display("FAIL half_latency got=%0d exp=16", lat); else pass_cnt++;
  endtask

  task automatic test_nan_lane();
    logic [127:0] v, gv, ev; logic [7:0] gn, en; int lat, np; bit to;
    lat_min = 1; lat_max = 3; stall_en = 1;
    v = {LANES{16'h4400}};
    v[16*2 +: 16] = 16'hBC00;
    model(v, 8'hFF, ev, en);
    run_vector(v, 8'hFF, gv, gn, lat, np, to);
    total_cnt++; if (to || gv !== ev) $display("FAIL nan_vec got=%h exp=%h", gv, ev); else pass_cnt++;
    total_cnt++; if (gn !== 8'h04) $display("FAIL nan_flags got=%h exp=04", gn); else pass_cnt++;
  endtask

  task automatic test_zero_mask();
    logic [127:0] v, gv; logic [7:0] gn; int lat, np; bit to;
    v = {$urandom, $urandom, $urandom, $urandom};
    run_vector(v, 8'h00, gv, gn, lat, np, to);
    total_cnt++; if (to || gv !== v) $display("FAIL zero_vec got=%h exp=%h", gv, v); else pass_cnt++;
    total_cnt++; if (np != 0 || gn !== 8'h00) $display("FAIL zero_pulses got=%0d/%h exp=0/00", np, gn); else pass_cnt++;
    total_cnt++; if (lat != LANES) $display("FAIL zero_latency got=%0d exp=%0d", lat, LANES); else pass_cnt++;
  endtask

  task automatic test_out_stall();
    logic [127:0] v, ev, cv; logic [7:0] en, cn; int n, p; bit ok;
    lat_min = 1; lat_max = 2; stall_en = 0;
    v = {LANES{16'h3C00}};
    v[16*2 +: 16] = 16'hBC00;
    model(v, 8'hFF, ev, en);
    @(negedge CLK);
    in_valid = 1'b1; in_vec = v; in_mask = 8'hFF;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 500) begin @(posedge CLK); #1; n++; end
    cv = out_vec; cn = out_nan;
    total_cnt++; if (!out_valid || cv !== ev || cn !== en) $display("FAIL stall_result got=%h/%h exp=%h/%h", cv, cn, ev, en); else pass_cnt++;
    ok = 1;
    p = pulses;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_vec = {$urandom, $urandom, $urandom, $urandom}; in_mask = 8'hFF;
      @(posedge CLK); #1;
      if (out_valid !== 1'b1 || out_vec !== cv || out_nan !== cn || in_ready !== 1'b0) ok = 0;
    end
    total_cnt++; if (!ok) $display("FAIL stall_hold got=%b/%h/%h exp=1/%h/%h", out_valid, out_vec, out_nan, cv, cn); else pass_cnt++;
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL stall_release got=%b/%b exp=1/0", in_ready, out_valid); else pass_cnt++;
    repeat (3) @(posedge CLK);
    #1;
    total_cnt++; if (in_ready !== 1'b1 || pulses != p) $display("FAIL stall_no_accept got=%b/%0d exp=1/%0d", in_ready, pulses, p); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    logic [127:0] v, gv, ev; logic [7:0] gn, en; int lat, np, n, p0; bit to;
    lat_min = 12; lat_max = 12; stall_en = 0;
    v = {LANES{16'h4400}};
    @(negedge CLK);
    in_valid = 1'b1; in_vec = v; in_mask = 8'hFF;
    p0 = pulses;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge CLK);
    while (pulses - p0 < 4 && n < 500) begin @(negedge CLK); n++; end
    total_cnt++; if (pulses - p0 != 4) $display("FAIL rst_reach_lane3 got=%0d exp=4", pulses - p0); else pass_cnt++;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rst_abort got=%b/%b exp=1/0", in_ready, out_valid); else pass_cnt++;
    lat_min = 1; lat_max = 3;
    model(v, 8'hFF, ev, en);
    run_vector(v, 8'hFF, gv, gn, lat, np, to);
    total_cnt++; if (to || gv !== ev || gn !== en || np != 8) $display("FAIL rst_recover got=%h/%h/%0d exp=%h/%h/8", gv, gn, np, ev, en); else pass_cnt++;
  endtask

  task automatic test_spurious();
    logic [127:0] v, gv; logic [7:0] gn; int lat, np; bit to;
    @(negedge CLK);
    spur_vo = 1'b1; spur_data = 16'h7E00;
    @(negedge CLK);
    spur_vo = 1'b0;
    v = {$urandom, $urandom, $urandom, $urandom};
    run_vector(v, 8'h00, gv, gn, lat, np, to);
    total_cnt++; if (to || gv !== v || gn !== 8'h00) $display("FAIL spurious got=%h/%h exp=%h/00", gv, gn, v); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] va, vb, ev; logic [7:0] mb, en; int n;
    lat_min = 1; lat_max = 3; stall_en = 1;
    va = {$urandom, $urandom, $urandom, $urandom};
    vb = {$urandom, $urandom, $urandom, $urandom};
    mb = 8'($urandom);
    @(negedge CLK);
    in_valid = 1'b1; in_vec = va; in_mask = 8'h5A;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 500) begin @(posedge CLK); #1; n++; end
    @(negedge CLK);
    out_ready = 1'b1; in_valid = 1'b1; in_vec = vb; in_mask = mb;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_turnaround got=%b/%b exp=1/0", in_ready, out_valid); else pass_cnt++;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_accept got=%b exp=0", in_ready); else pass_cnt++;
    n = 0;
    while (!out_valid && n < 500) begin @(posedge CLK); #1; n++; end
    model(vb, mb, ev, en);
    total_cnt++; if (!out_valid || out_vec !== ev || out_nan !== en) $display("FAIL b2b_result got=%h/%h exp=%h/%h", out_vec, out_nan, ev, en); else pass_cnt++;
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] v, gv, ev; logic [7:0] m, gn, en; int lat, np, pc; bit to;
    logic [15:0] picks [4];
    lat_min = 1; lat_max = 4; stall_en = 1;
    picks[0] = 16'h4400; picks[1] = 16'h3C00; picks[2] = 16'hBC00;
    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < LANES; i++) begin
        picks[3] = 16'($urandom);
        v[16*i +: 16] = picks[$urandom_range(3, 0)];
      end
      m = 8'($urandom);
      pc = $countones(m);
      model(v, m, ev, en);
      run_vector(v, m, gv, gn, lat, np, to);
      total_cnt++; if (to || gv !== ev || gn !== en) $display("FAIL random_%0d got=%h/%h exp=%h/%h", k, gv, gn, ev, en); else pass_cnt++;
      total_cnt++; if (np != pc) $display("FAIL random_pulses_%0d got=%0d exp=%0d", k, np, pc); else pass_cnt++;
    end
    total_cnt++; if (proto_err != 0) $display("FAIL random_inflight got=%0d exp=0", proto_err); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; pulses = 0; proto_err = 0;
    lat_min = 1; lat_max = 1; stall_en = 0;
    stub_vo = 1'b0; stub_do = '0; stub_busy = 1'b0; stub_lat = 0; stub_held = '0;
    spur_vo = 1'b0; spur_data = '0;
    sq_ready = 1'b1;
    in_valid = 1'b0; in_vec = '0; in_mask = '0; out_ready = 1'b0;
    RST = 1'b1;
    test_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    test_full_mask();
    test_half_mask();
    test_nan_lane();
    test_zero_mask();
    test_out_stall();
    test_reset_mid_wait();
    test_spurious();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vsqrt_seq.md
# vsqrt_seq

Vector-to-scalar sequencer that sits directly upstream of the FP16 square-root unit in the vector datapath. Accepts one LANES-wide FP16 vector plus a lane mask, issues each enabled lane to the scalar sqrt unit one at a time, and collects the returned results into an output vector. Disabled lanes pass through unchanged. The sequencer also reports a per-lane NaN flag.

## Interface
Parameters:
- LANES, 8, number of FP16 elements per vector (≥2)
- IDX_W, $clog2(LANES), lane index width

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high; the sqrt unit's nRST is driven by ~RST at the wrapper
- in_valid  in  1  input vector valid
- in_ready  out  1  sequencer can accept a vector
- in_vec  in  LANES*16  FP16 elements; lane i at [16*i+15:16*i]
- in_mask  in  LANES  1 = compute sqrt on lane, 0 = pass through
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result
- out_vec  out  LANES*16  result elements
- out_nan  out  LANES  per-lane flag: enabled lane returned a NaN (exp==5'h1F, frac!=0)
- sq_valid_in  out  1  element valid to sqrt unit
- sq_ready  in  1  sqrt unit idle/ready
- sq_data_in  out  16  FP16 element to sqrt unit
- sq_valid_out  in  1  sqrt result pulse (single cycle, no backpressure)
- sq_data_out  in  16  sqrt result

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_vec into result buffer and in_mask into mask register; clear out_nan; idx=0; go to ISSUE.
- ISSUE, lane idx:
  - Disabled lane (mask[idx]=0): buffer lane keeps its input value. If idx==LANES-1 go to DONE, else idx+1 and stay in ISSUE. One cycle per disabled lane; no find-first skipping.
  - Enabled lane with sq_ready=1: assert sq_valid_in for exactly this cycle, with sq_data_in = buffer[idx]. Go to WAIT.
  - Enabled lane with sq_ready=0: stay in ISSUE with sq_valid_in=0.
- WAIT:
  - On sq_valid_out: write sq_data_out into buffer[idx]; set out_nan[idx] if the result is NaN. If idx==LANES-1 go to DONE, else idx+1 and go to ISSUE.
  - Otherwise hold.
- DONE:
  - out_valid=1. out_vec and out_nan are held stable.
  - On out_ready: go to IDLE.
- sq_valid_out outside WAIT is ignored. No buffer or flag update occurs.
- in_ready=0 in all states except IDLE. Input vectors are never queued.
- The sequencer performs no arithmetic. All special-case results (NaN 0x7D00, +Inf, ±0, subnormal→0) come from the sqrt unit unchanged.
- Only one element is in flight at any time. sq_valid_in is never reasserted before the matching sq_valid_out.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, sq_valid_in=0, sq_data_in=0, out_vec=0, out_nan=0, idx=0.
- RST asserted mid-operation (any state) aborts the vector immediately. The partial result is discarded and out_valid is not asserted. The sqrt unit is reset concurrently, so no stale sq_valid_out can arrive afterwards.
- Cycle 0: accept edge (in_valid & in_ready). Cycle 1: first ISSUE.
- Per-lane cost:
  - Disabled lane: 1 cycle.
  - Enabled lane: 1 ISSUE cycle + W WAIT cycles, where W counts up to and including the sq_valid_out cycle.
- out_valid rises the cycle after the last lane completes.
- All-zero mask: out_valid rises at cycle LANES+1, with out_vec == in_vec.
- DONE→IDLE on the out_ready edge. A new vector can be accepted at the earliest on the following cycle; there is no same-cycle turnaround.
- in_vec/in_mask changes while in_ready=0 have no effect.

## Structure
- vector_pkg additions:
  - VSQ_LANES default constant
  - vsqrt_seq_state_t enum {IDLE, ISSUE, WAIT, DONE}
  - fp16_is_nan function (exp all ones, frac nonzero)
- Existing fp16_t is used for lane slicing.
- No sub-module. The sqrt unit is instantiated beside this block in the vector-sqrt wrapper, not inside it.

## Test plan
- LANES=8, mask=8'hFF, every lane 0x4400 (4.0) -> out_vec all lanes 0x4000 (2.0); out_nan=0; exactly 8 sq_valid_in pulses.
- mask=8'h0F, lanes 0x3C00 (1.0) -> lanes 0-3 = 0x3C00 from sqrt; lanes 4-7 equal to their inputs; 4 sq_valid_in pulses.
- lane 2 = 0xBC00 (-1.0), others 0x4400, mask=8'hFF -> lane 2 = 0x7D00, out_nan=8'h04; other lanes 0x4000.
- mask=8'h00 -> zero sq_valid_in pulses; out_valid at cycle 9 after accept; out_vec == in_vec.
- out_ready held low 20 cycles in DONE -> out_valid, out_vec and out_nan stable; in_ready stays 0; a new in_valid is not accepted.
- RST pulsed while in WAIT on lane 3 -> in_ready=1 and out_valid=0 the cycle after RST; a following vector {0x4400 x8} completes correctly.
